tt_um_aksp_mbist_mbisr_core: RTL and testbench

TT_UM_AKSP_MBIST_MBISR_CORE -- requirements
Module: tt_um_aksp_mbist_mbisr

---
 rtl/tt_um_aksp_mbist_mbisr_core_if.sv | 16 +
 rtl/tt_um_aksp_mbist_mbisr_core.sv | 224 ++++++++++++++++++++++
 tb/tb_tt_um_aksp_mbist_mbisr_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tt_um_aksp_mbist_mbisr_core_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_aksp_mbist_mbisr_core_if
// Brief    : Pin bundle of the MBIST/MBISR core (enable, inputs, status, debug)
// Revision : 1.0
// ============================================================================
interface tt_um_aksp_mbist_mbisr_core_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio;

    modport master (output ena, output ui_in, input uo_out, input uio);
    modport slave  (input ena, input ui_in, output uo_out, output uio);
endinterface
`default_nettype wire

// File: rtl/tt_um_aksp_mbist_mbisr_core.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_aksp_mbist_mbisr_core
// Brief    : 16x8 memory with March C- self test and two-spare self repair
// Revision : 1.0
// ============================================================================
module tt_um_aksp_mbist_mbisr_core (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    tt_um_aksp_mbist_mbisr_core_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_LAST_ELEM = 3'd5;

    logic [7:0]      mem_q [16];
    logic [1:0][7:0] spare_mem_q;

    state_t          state_q, state_d;
    logic [2:0]      elem_q, elem_d;
    logic [3:0]      addr_q, addr_d;
    logic            op_q, op_d;
    logic            pass_q, pass_d;
    logic [3:0]      err_cnt_q, err_cnt_d;
    logic            overflow_q, overflow_d;
    logic            pass2_err_q, pass2_err_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic            repaired_q, repaired_d;
    logic            start_prev_q, start_prev_d;
    logic [1:0]      spare_valid_q, spare_valid_d;
    logic [1:0][3:0] spare_addr_q, spare_addr_d;

    logic       w_start_edge, w_down, w_two_op, w_is_read, w_ones;
    logic [3:0] w_eff_addr;
    logic [7:0] w_pat, w_rd_main, w_rd_data;
    logic [1:0] w_hit, w_alloc;
    logic       w_mismatch;
    logic       w_unused;

    assign w_unused     = &{1'b0, bus.ui_in[7:6]};
    assign w_start_edge = bus.ui_in[0] & ~start_prev_q;
    assign start_prev_d = bus.ui_in[0];

    // Elements 3 and 4 walk the address space downward.
    assign w_down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign w_eff_addr = w_down ? ~addr_q : addr_q;
    assign w_two_op   = (elem_q != 3'd0) && (elem_q != C_LAST_ELEM);
    assign w_is_read  = (elem_q == C_LAST_ELEM) || (w_two_op && !op_q);
    assign w_ones     = w_two_op && (op_q ^ ((elem_q == 3'd2) || (elem_q == 3'd4)));
    assign w_pat      = w_ones ? 8'hFF : 8'h00;

    assign w_hit[0] = spare_valid_q[0] && (spare_addr_q[0] == w_eff_addr);
    assign w_hit[1] = spare_valid_q[1] && (spare_addr_q[1] == w_eff_addr) && !w_hit[0];

    always_comb begin
        w_rd_main = mem_q[w_eff_addr];
        if (bus.ui_in[1] && (bus.ui_in[5:2] == w_eff_addr)) begin
            w_rd_main[0] = 1'b0;
        end
    end

    assign w_rd_data  = w_hit[0] ? spare_mem_q[0] : (w_hit[1] ? spare_mem_q[1] : w_rd_main);
    assign w_mismatch = (state_q == S_MARCH) && w_is_read && (w_rd_data != w_pat);

    always_comb begin
        state_d       = state_q;
        elem_d        = elem_q;
        addr_d        = addr_q;
        op_d          = op_q;
        pass_d        = pass_q;
        err_cnt_d     = err_cnt_q;
        overflow_d    = overflow_q;
        pass2_err_d   = pass2_err_q;
        done_d        = done_q;
        fail_d        = fail_q;
        repaired_d    = repaired_q;
        spare_valid_d = spare_valid_q;
        spare_addr_d  = spare_addr_q;
        w_alloc       = 2'b00;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start_edge) begin
                    state_d       = S_MARCH;
                    elem_d        = 3'd0;
                    addr_d        = 4'd0;
                    op_d          = 1'b0;
                    pass_d        = 1'b0;
                    err_cnt_d     = 4'd0;
                    overflow_d    = 1'b0;
                    pass2_err_d   = 1'b0;
                    done_d        = 1'b0;
                    fail_d        = 1'b0;
                    repaired_d    = 1'b0;
                    spare_valid_d = 2'b00;
                    spare_addr_d  = '0;
                end
            end
            S_MARCH: begin
                // The displayed error count covers pass 1; pass 2 only records pass/fail.
                if (w_mismatch) begin
                    if (!pass_q) begin
                        if (err_cnt_q != 4'hF) begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                        if (w_hit == 2'b00) begin
                            if (!spare_valid_q[0]) begin
                                spare_valid_d[0] = 1'b1;
                                spare_addr_d[0]  = w_eff_addr;
                                w_alloc[0]       = 1'b1;
                            end else if (!spare_valid_q[1]) begin
                                spare_valid_d[1] = 1'b1;
                                spare_addr_d[1]  = w_eff_addr;
                                w_alloc[1]       = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end else begin
                        pass2_err_d = 1'b1;
                    end
                end
                if (w_two_op && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d   = 1'b0;
                    addr_d = addr_q + 4'd1;
                    if (addr_q == 4'hF) begin
                        if (elem_q == C_LAST_ELEM) begin
                            elem_d  = 3'd0;
                            state_d = S_EVAL;
                        end else begin
                            elem_d = elem_q + 3'd1;
                        end
                    end
                end
            end
            S_EVAL: begin
                if (pass_q) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    fail_d     = pass2_err_q;
                    repaired_d = !pass2_err_q;
                end else if (err_cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (overflow_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    pass_d  = 1'b1;
                    state_d = S_MARCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= S_IDLE;
            elem_q        <= 3'd0;
            addr_q        <= 4'd0;
            op_q          <= 1'b0;
            pass_q        <= 1'b0;
            err_cnt_q     <= 4'd0;
            overflow_q    <= 1'b0;
            pass2_err_q   <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            repaired_q    <= 1'b0;
            start_prev_q  <= 1'b0;
            spare_valid_q <= 2'b00;
            spare_addr_q  <= '0;
        end else if (bus.ena) begin
            state_q       <= state_d;
            elem_q        <= elem_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            pass_q        <= pass_d;
            err_cnt_q     <= err_cnt_d;
            overflow_q    <= overflow_d;
            pass2_err_q   <= pass2_err_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            repaired_q    <= repaired_d;
            start_prev_q  <= start_prev_d;
            spare_valid_q <= spare_valid_d;
            spare_addr_q  <= spare_addr_d;
        end
    end

    // A freshly allocated spare is loaded with the expected value so the rest of the pass sees good data.
    always_ff @(posedge clk) begin
        if (!rst_n && bus.ena && (state_q == S_MARCH)) begin
            if (!w_is_read) begin
                if (w_hit[0]) begin
                    spare_mem_q[0] <= w_pat;
                end else if (w_hit[1]) begin
                    spare_mem_q[1] <= w_pat;
                end else begin
                    mem_q[w_eff_addr] <= w_pat;
                end
            end
            if (w_alloc[0]) begin
                spare_mem_q[0] <= w_pat;
            end
            if (w_alloc[1]) begin
                spare_mem_q[1] <= w_pat;
            end
        end
    end

    assign bus.uo_out = {err_cnt_q, (state_q == S_MARCH) || (state_q == S_EVAL),
                         repaired_q, fail_q, done_q};
    assign bus.uio    = {elem_q, pass_q, w_eff_addr};
endmodule
`default_nettype wire

// File: tb/tb_tt_um_aksp_mbist_mbisr_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_aksp_mbist_mbisr_core
// Brief    : Scoreboard bench for the MBIST/MBISR core
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tt_um_aksp_mbist_mbisr_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    tt_um_aksp_mbist_mbisr_core_if bus ();

    tt_um_aksp_mbist_mbisr_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    lat;
        int    fail;
        int    rep;
        int    cnt;
        bit    chk_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   base  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_now();
        return cyc - base;
    endfunction

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        while (n_now() < n) @(negedge clk);
    endtask

    // Issue a 2-cycle start pulse; the run's expected outcome goes on the scoreboard.
    task automatic pulse_start(input bit push, input exp_t e);
        @(negedge clk);
        bus.ui_in[0] = 1'b1;
        base = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        check_val({e.tag, "_busy"}, int'(bus.uo_out[3]), 1);
        check_val({e.tag, "_done_clr"}, int'(bus.uo_out[0]), 0);
        @(negedge clk);
        bus.ui_in[0] = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        exp_t e;
        while (bus.uo_out[0] !== 1'b1 && n_now() < limit) @(negedge clk);
        e = sb.pop_front();
        check_val({e.tag, "_lat"}, n_now(), e.lat);
        check_val({e.tag, "_fail"}, int'(bus.uo_out[1]), e.fail);
        check_val({e.tag, "_rep"}, int'(bus.uo_out[2]), e.rep);
        if (e.chk_cnt) check_val({e.tag, "_cnt"}, int'(bus.uo_out[7:4]), e.cnt);
    endtask

    initial begin
        logic [7:0] snap_uo;
        logic [7:0] snap_uio;
        bus.ena   = 1'b1;
        bus.ui_in = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_uo", int'(bus.uo_out), 0);
        check_val("rst_uio", int'(bus.uio), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        pulse_start(1'b1, '{"clean", 162, 0, 0, 0, 1'b1});
        wait_done(400);

        bus.ui_in[5:2] = 4'd5;
        bus.ui_in[1]   = 1'b1;
        pulse_start(1'b1, '{"repair", 323, 0, 1, 1, 1'b1});
        wait_done(400);
        bus.ui_in[1] = 1'b0;

        bus.ui_in[5:2] = 4'd2;
        bus.ui_in[1]   = 1'b1;
        pulse_start(1'b1, '{"ovfl", 162, 1, 0, 3, 1'b1});
        fork
            begin
                wait_n(56); bus.ui_in[5:2] = 4'd6;
                wait_n(64); bus.ui_in[5:2] = 4'd10;
                wait_n(72); bus.ui_in[1]   = 1'b0;
            end
            wait_done(400);
        join

        bus.ui_in[5:2] = 4'd5;
        bus.ui_in[1]   = 1'b1;
        pulse_start(1'b1, '{"p2fail", 323, 1, 0, 1, 1'b0});
        fork
            begin
                wait_n(170); bus.ui_in[5:2] = 4'd7;
            end
            wait_done(400);
        join
        bus.ui_in[1] = 1'b0;

        pulse_start(1'b1, '{"ignore", 162, 0, 0, 0, 1'b1});
        fork
            begin
                wait_n(80); bus.ui_in[0] = 1'b1;
                wait_n(82); bus.ui_in[0] = 1'b0;
            end
            wait_done(400);
        join

        pulse_start(1'b1, '{"ena", 212, 0, 0, 0, 1'b1});
        fork
            begin
                wait_n(100);
                snap_uo  = bus.uo_out;
                snap_uio = bus.uio;
                bus.ena  = 1'b0;
                repeat (50) @(negedge clk);
                check_val("ena_uo_hold", int'(bus.uo_out), int'(snap_uo));
                check_val("ena_uio_hold", int'(bus.uio), int'(snap_uio));
                bus.ena = 1'b1;
            end
            wait_done(400);
        join

        pulse_start(1'b0, '{"abort", 0, 0, 0, 0, 1'b0});
        wait_n(90);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_uo", int'(bus.uo_out), 0);
        check_val("abort_uio", int'(bus.uio), 0);
        rst_n = 1'b0;
        repeat (200) @(negedge clk);
        check_val("abort_idle", int'(bus.uo_out), 0);

        pulse_start(1'b1, '{"after", 162, 0, 0, 0, 1'b1});
        wait_done(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
